// File: rtl/ls279_pkg.sv
// Shared types and constants for the SN74LS279 drive sequencer.
package ls279_pkg;

  localparam int CNT_W = 8;
  localparam int NCH   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SET_P = 2'd1,
    ST_CLR_P = 2'd2,
    ST_GAP   = 2'd3
  } chan_state_e;

  // Down-counter load value for a phase lasting `cycles` clocks.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/ls279_drive_chan.sv
// One LS279 latch channel: request FSM, pulse/gap down-counter, optional Q readback.
// Readback compare is built only when LS279_READBACK_EN is defined.
//
// state    | meaning
// ST_IDLE  | both inputs high, waiting for a request
// ST_SET_P | /S held low for PW cycles
// ST_CLR_P | /R held low for PW cycles
// ST_GAP   | both inputs high for GAP cycles while the latch settles
module ls279_drive_chan
  import ls279_pkg::*;
#(
  parameter int unsigned PW  = 2,
  parameter int unsigned GAP = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
`ifdef LS279_READBACK_EN
  input  logic q,
`endif
  output logic s_n,
  output logic r_n,
  output logic ack,
  output logic busy,
  output logic err
);

  localparam logic [CNT_W-1:0] PW_LD  = cnt_load(PW);
  localparam logic [CNT_W-1:0] GAP_LD = cnt_load(GAP);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_n_q, s_n_d;
  logic             r_n_q, r_n_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             cnt_zero;
  logic             can_accept;

`ifdef LS279_READBACK_EN
  logic             last_set_q, last_set_d;
  logic             err_q, err_d;
`endif

  assign cnt_zero   = (cnt_q == '0);
  // The final GAP cycle behaves like IDLE so a held request sees PW+GAP occupancy.
  assign can_accept = (state_q == ST_IDLE) || ((state_q == ST_GAP) && cnt_zero);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_n_d   = 1'b1;
    r_n_d   = 1'b1;
    ack_d   = 1'b0;
    busy_d  = busy_q;
`ifdef LS279_READBACK_EN
    last_set_d = last_set_q;
    err_d      = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_SET_P: begin
        busy_d = 1'b1;
        if (cnt_zero) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          s_n_d = 1'b0;
        end
      end
      ST_CLR_P: begin
        busy_d = 1'b1;
        if (cnt_zero) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          r_n_d = 1'b0;
        end
      end
      ST_GAP: begin
        busy_d = 1'b1;
        if (cnt_zero) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Clear has priority so /S and /R are never both driven low.
    if (can_accept && (set_req || clr_req)) begin
      ack_d  = 1'b1;
      busy_d = 1'b1;
      cnt_d  = PW_LD;
      if (clr_req) begin
        state_d = ST_CLR_P;
        r_n_d   = 1'b0;
      end else begin
        state_d = ST_SET_P;
        s_n_d   = 1'b0;
      end
`ifdef LS279_READBACK_EN
      last_set_d = !clr_req;
      err_d      = 1'b0;
`endif
    end

`ifdef LS279_READBACK_EN
    // Mismatch from the finishing operation beats the clear of a back-to-back accept,
    // otherwise a held request would hide every failure. An x on q lands in else.
    if ((state_q == ST_GAP) && cnt_zero) begin
      if (q == last_set_q) begin
        err_d = err_d;
      end else begin
        err_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      s_n_q   <= 1'b1;
      r_n_q   <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef LS279_READBACK_EN
      last_set_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_n_q   <= s_n_d;
      r_n_q   <= r_n_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
`ifdef LS279_READBACK_EN
      last_set_q <= last_set_d;
      err_q      <= err_d;
`endif
    end
  end

  assign s_n  = s_n_q;
  assign r_n  = r_n_q;
  assign ack  = ack_q;
  assign busy = busy_q;
`ifdef LS279_READBACK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: rtl/ls279_drive_seq.sv
// Quad SN74LS279 /S-/R pulse sequencer: NCH independent ls279_drive_chan instances.
// Q readback and err flags exist only when LS279_READBACK_EN is defined.
module ls279_drive_seq
  import ls279_pkg::*;
#(
  parameter int unsigned PW  = 2,
  parameter int unsigned GAP = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] set_req,
  input  logic [NCH-1:0] clr_req,
  input  logic [NCH-1:0] q,
  output logic [NCH-1:0] s_n,
  output logic [NCH-1:0] r_n,
  output logic [NCH-1:0] ack,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] err
);

`ifndef LS279_READBACK_EN
  logic unused_q;
  assign unused_q = ^q;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    ls279_drive_chan #(
      .PW  (PW),
      .GAP (GAP)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .set_req (set_req[i]),
      .clr_req (clr_req[i]),
`ifdef LS279_READBACK_EN
      .q       (q[i]),
`endif
      .s_n     (s_n[i]),
      .r_n     (r_n[i]),
      .ack     (ack[i]),
      .busy    (busy[i]),
      .err     (err[i])
    );
  end

endmodule

// File: tb/tb_ls279_drive_seq.sv
// Scoreboard bench for ls279_drive_seq (PW=2, GAP=2); readback rows expect err when
// LS279_READBACK_EN is defined.
module tb_ls279_drive_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] set_req, clr_req, q;
  logic [3:0] s_n, r_n, ack, busy, err;
  logic [2:0] q_model;

  typedef struct {
    logic       rst;
    logic [3:0] set;
    logic [3:0] clr;
    logic [3:0] s_n;
    logic [3:0] r_n;
    logic [3:0] ack;
    logic [3:0] busy;
    logic [3:0] err;
  } vec_t;

  typedef struct {
    int         row;
    logic [3:0] s_n;
    logic [3:0] r_n;
    logic [3:0] ack;
    logic [3:0] busy;
    logic [3:0] err;
  } exp_t;

`ifdef LS279_READBACK_EN
  localparam logic [3:0] ERR3 = 4'h8;
`else
  localparam logic [3:0] ERR3 = 4'h0;
`endif

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  ls279_drive_seq #(.PW(2), .GAP(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .set_req (set_req),
    .clr_req (clr_req),
    .q       (q),
    .s_n     (s_n),
    .r_n     (r_n),
    .ack     (ack),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Ideal latch on channels 0..2; channel 3 Q is stuck low.
  initial q_model = 3'b000;
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!s_n[i])      q_model[i] <= 1'b1;
      else if (!r_n[i]) q_model[i] <= 1'b0;
    end
  end
  assign q = {1'b0, q_model};

  task automatic addv(input logic r, input logic [3:0] st, input logic [3:0] cl,
                      input logic [3:0] es, input logic [3:0] er, input logic [3:0] ea,
                      input logic [3:0] eb, input logic [3:0] ee);
    vec_t v;
    v.rst = r; v.set = st; v.clr = cl;
    v.s_n = es; v.r_n = er; v.ack = ea; v.busy = eb; v.err = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [3:0] got,
                     input logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL row%0d %s got=%h expected=%h", row, name, got, want);
    end
  endtask

  // Monitor: pops one expectation per clock, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("s_n", e.row, s_n, e.s_n);
        chk("r_n", e.row, r_n, e.r_n);
        chk("ack", e.row, ack, e.ack);
        chk("busy", e.row, busy, e.busy);
        chk("err", e.row, err, e.err);
        chk("s_n|r_n", e.row, s_n | r_n, 4'hF);
      end
    end
  end

  initial begin
    exp_t e;
    int   wait_cyc;
    rst = 1'b1; set_req = 4'h0; clr_req = 4'h0;

    // rst set clr     s_n   r_n   ack   busy  err
    addv(1, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);   // 0 reset
    addv(1, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    addv(1, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);   // 3 released, idle
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    addv(0, 4'h1, 4'h0, 4'hE, 4'hF, 4'h1, 4'h1, 4'h0);   // 5 set ch0
    addv(0, 4'h0, 4'h0, 4'hE, 4'hF, 4'h0, 4'h1, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h1, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h1, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);   // 9 busy falls
    addv(0, 4'h4, 4'h4, 4'hF, 4'hB, 4'h4, 4'h4, 4'h0);   // 10 set+clr ch2, clear wins
    addv(0, 4'h0, 4'h0, 4'hF, 4'hB, 4'h0, 4'h4, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h4, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h4, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    addv(0, 4'h0, 4'h2, 4'hF, 4'hD, 4'h2, 4'h2, 4'h0);   // 15 clr ch1 held
    addv(0, 4'h0, 4'h2, 4'hF, 4'hD, 4'h0, 4'h2, 4'h0);
    addv(0, 4'h0, 4'h2, 4'hF, 4'hF, 4'h0, 4'h2, 4'h0);
    addv(0, 4'h0, 4'h2, 4'hF, 4'hF, 4'h0, 4'h2, 4'h0);
    addv(0, 4'h0, 4'h2, 4'hF, 4'hD, 4'h2, 4'h2, 4'h0);   // 19 re-accept 4 later
    addv(0, 4'h0, 4'h2, 4'hF, 4'hD, 4'h0, 4'h2, 4'h0);
    addv(0, 4'h0, 4'h2, 4'hF, 4'hF, 4'h0, 4'h2, 4'h0);
    addv(0, 4'h0, 4'h2, 4'hF, 4'hF, 4'h0, 4'h2, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);   // 23 dropped
    addv(0, 4'h1, 4'h0, 4'hE, 4'hF, 4'h1, 4'h1, 4'h0);   // 24 set ch0
    addv(0, 4'h0, 4'h0, 4'hE, 4'hF, 4'h0, 4'h1, 4'h0);
    addv(1, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);   // 26 abort by rst
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    addv(1, 4'h8, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);   // 30 request under rst
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
    addv(0, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0);   // 32 set all
    addv(0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, ERR3);   // 36 ch3 Q stuck low
    addv(0, 4'h8, 4'h0, 4'h7, 4'hF, 4'h8, 4'h8, 4'h0);   // 37 accept clears err
    addv(0, 4'h0, 4'h0, 4'h7, 4'hF, 4'h0, 4'h8, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h8, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h8, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, ERR3);   // 41 err after last GAP
    addv(0, 4'h0, 4'h8, 4'hF, 4'h7, 4'h8, 4'h8, 4'h0);   // 42 clr ch3 clears err
    addv(0, 4'h0, 4'h0, 4'hF, 4'h7, 4'h0, 4'h8, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h8, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h8, 4'h0);
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);   // 46 Q=0 matches clear
    addv(0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst     = vecs[k].rst;
      set_req = vecs[k].set;
      clr_req = vecs[k].clr;
      e.row  = k;
      e.s_n  = vecs[k].s_n;
      e.r_n  = vecs[k].r_n;
      e.ack  = vecs[k].ack;
      e.busy = vecs[k].busy;
      e.err  = vecs[k].err;
      exp_q.push_back(e);
    end
    @(negedge clk);
    rst = 1'b0; set_req = 4'h0; clr_req = 4'h0;

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ls279_drive_seq.md
# ls279_drive_seq

Clocked sequencer driving the active-low /S and /R inputs of a quad SN74LS279 RS latch package, sitting directly upstream of it. Turns per-channel set/clear requests into fixed-width, non-overlapping low pulses. Guarantees /S and /R are never low together on one channel, so the latch never enters its unstable state. Optionally reads Q back and flags channels where the latch did not take the commanded value.

## Interface
- PW, 2, /S or /R low-pulse width in clk cycles; legal range 1..255
- GAP, 2, settle cycles after a pulse, both inputs high, before the channel returns to idle; legal range 1..255
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- set_req  input  4  per-channel request to drive Q high
- clr_req  input  4  per-channel request to drive Q low
- q  input  4  latch Q readback; used only with LS279_READBACK_EN
- s_n  output  4  to latch /S; active low
- r_n  output  4  to latch /R; active low
- ack  output  4  one-cycle pulse when a request is accepted
- busy  output  4  channel is in a pulse or gap
- err  output  4  sticky readback mismatch; constant 0 without LS279_READBACK_EN

## Operation
- Four independent identical channels. Each channel has states IDLE, SET_P, CLR_P and GAP.
- IDLE:
  - Requests are sampled on each rising clk edge.
  - set_req=1 → SET_P.
  - clr_req=1 → CLR_P.
  - Both =1 → CLR_P; clear wins.
  - Acceptance raises ack for exactly that cycle and loads the 8-bit counter with PW-1.
- SET_P: s_n=0, r_n=1. Counter decrements each cycle; at 0 → GAP, counter loaded with GAP-1.
- CLR_P: r_n=0, s_n=1. Same counting as SET_P.
- GAP: s_n=r_n=1, busy=1. At counter 0 → IDLE. With readback enabled, q is compared on this last GAP cycle.
- Requests arriving while busy are ignored. They are not queued and produce no ack; a held request is accepted on the first IDLE cycle.
- Invariant: s_n|r_n == 1 on every channel at every cycle, including reset.
- Reset value of all outputs: s_n=4'hF, r_n=4'hF, ack=0, busy=0, err=0. All channels go to IDLE.
- rst during SET_P, CLR_P or GAP aborts the pulse: outputs are inactive from the edge where rst is sampled. No ack occurs in that cycle.

## Timing
- Request sampled at edge N → ack, busy and pulse-low are all registered at edge N.
- The pulse is low for edges N..N+PW-1 and returns high at edge N+PW.
- busy falls at edge N+PW+GAP, so the earliest next acceptance is at that same edge.
- Per-request occupancy is PW+GAP cycles.
- All outputs are registered; there is no combinational path from input to output.
- GAP×Tclk must be at least the latch tPHL max (27 ns) when readback is enabled. This is an integration requirement and is not checked in RTL.

## Configuration
- LS279_READBACK_EN defined:
  - On the last GAP cycle, the expected value is 1 after SET_P and 0 after CLR_P.
  - If q[i] differs from the expected value, err[i] is set at the next edge.
  - err[i] is cleared by rst or by the next accepted request on that channel.
  - An x on q counts as a mismatch.
- Not defined: q is unconnected internally, err is tied 4'h0, and there is no compare logic.

## Structure
- Shared package ls279_pkg holds:
  - the state enum (IDLE, SET_P, CLR_P, GAP)
  - the counter width constant CNT_W=8
  - the channel count NCH=4
- Sub-module ls279_drive_chan implements one channel (FSM, counter, optional compare). It is instantiated NCH times by the top. The top contains only wiring and parameter pass-through.

## Test plan
- Reset, PW=2, GAP=2: hold rst 3 cycles → s_n=r_n=F, busy=ack=err=0. Release; no requests → outputs unchanged.
- set_req[0] pulse at edge 5 → ack[0]=1 at edge 5 only; s_n[0]=0 at edges 5–6; busy[0] high for edges 5–8, falls at edge 9; other channels idle.
- set_req[2] and clr_req[2] both high at the same edge → r_n[2] low for 2 cycles, s_n[2] stays 1. Assert s_n|r_n==F every cycle for the whole run.
- clr_req[1] held high continuously → ack[1] pulses every 4 cycles. Requests during busy produce no ack.
- rst asserted during the second SET_P cycle → s_n=F and busy=0 at that edge; no further pulse afterwards.
- LS279_READBACK_EN defined, q[3] tied 0, set_req[3] issued → err[3]=1 after the last GAP edge. A following clr_req[3] clears err[3] at ack, and err[3] stays 0 after that sequence.
